wc_tile_feeder: RTL and testbench

- Upstream stage of the F(2,5) Winograd core `WC` (6 x 10-bit input tile D, 2 x 10-bit outputs Z).
- Accepts a serial stream of 10-bit samples, one per cycle, with a valid/ready handshake.
- Builds overlapping 6-sample windows at stride 2 within each fixed-length row and presents each window as one packed tile on the D bus.
- Rows are independent: no window spans a row boundary.

---
 rtl/wc_pkg.sv | 12 +
 rtl/wc_window_sreg.sv | 28 ++
 rtl/wc_tile_feeder.sv | 101 ++++++++++
 tb/tb_wc_tile_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wc_pkg.sv
// Shared constants and types for the F(2,5) Winograd core and its feeder.
package wc_pkg;

  localparam int unsigned WC_DW     = 10;
  localparam int unsigned WC_TILE   = 6;
  localparam int unsigned WC_STRIDE = 2;
  localparam int unsigned WC_OUT    = 2;

  typedef logic signed [WC_DW-1:0]         wc_sample_t;
  typedef logic        [WC_DW*WC_TILE-1:0] wc_tile_t;

endpackage

// File: rtl/wc_window_sreg.sv
// DEPTH-deep sample shift register; lane 0 is the oldest, lane DEPTH-1 the newest.
module wc_window_sreg #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DW-1:0]       data_i,
  output logic [DW*DEPTH-1:0] win_next_o
);

  logic [DW*DEPTH-1:0] win_q, win_d;

  // Look-ahead view: the window as it will be once data_i is shifted in.
  assign win_next_o = {data_i, win_q[DW*DEPTH-1:DW]};

  always_comb begin
    win_d = win_q;
    if (en_i) win_d = win_next_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) win_q <= '0;
    else       win_q <= win_d;
  end

endmodule

// File: rtl/wc_tile_feeder.sv
// Turns a row-structured sample stream into overlapping stride-2 tiles for the Winograd core.
module wc_tile_feeder
  import wc_pkg::*;
#(
  parameter int unsigned DW      = WC_DW,
  parameter int unsigned TILE    = WC_TILE,
  parameter int unsigned STRIDE  = WC_STRIDE,
  parameter int unsigned ROW_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [DW*TILE-1:0] D,
  output logic               d_first,
  output logic               d_last,
  output logic [15:0]        tile_cnt
);

  localparam int unsigned CW = $clog2(ROW_LEN);
  localparam logic [CW-1:0] FirstCol = CW'(TILE - 1);
  localparam logic [CW-1:0] LastCol  = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0] StrideC  = CW'(STRIDE);

  if ((ROW_LEN % 2) != 0 || ROW_LEN < TILE) begin : g_bad_row_len
    $error("wc_tile_feeder: ROW_LEN must be even and >= TILE");
  end

  logic               accept, trigger;
  logic [CW-1:0]      col_q, col_d;
  logic [DW*TILE-1:0] win_next, tile_q, tile_d;
  logic               valid_q, valid_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [15:0]        cnt_q, cnt_d;

  assign s_ready = !(valid_q && !d_ready);
  assign accept  = s_valid && s_ready;
  // Gating on col alone keeps stale samples of the previous row out of the first tile.
  assign trigger = accept && (col_q >= FirstCol) && (((col_q - FirstCol) % StrideC) == '0);

  wc_window_sreg #(
    .DW    (DW),
    .DEPTH (TILE)
  ) u_sreg (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (accept),
    .data_i     (s_data),
    .win_next_o (win_next)
  );

  always_comb begin
    col_d   = col_q;
    tile_d  = tile_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (accept) col_d = (col_q == LastCol) ? '0 : col_q + CW'(1);
    if (valid_q && d_ready) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + 16'd1;
    end
    // A new tile overrides the clear from a same-cycle handoff.
    if (trigger) begin
      valid_d = 1'b1;
      tile_d  = win_next;
      first_d = (col_q == FirstCol);
      last_d  = (col_q == LastCol);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      tile_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      col_q   <= col_d;
      tile_q  <= tile_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_valid  = valid_q;
  assign D        = tile_q;
  assign d_first  = first_q;
  assign d_last   = last_q;
  assign tile_cnt = cnt_q;

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Randomised and directed bench for wc_tile_feeder against a row-buffer reference model.
module tb_wc_tile_feeder;

  typedef struct packed {
    logic [59:0] d;
    logic        first;
    logic        last;
  } tile_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  s_data;
  logic        d_valid;
  logic        d_ready;
  logic [59:0] D;
  logic        d_first;
  logic        d_last;
  logic [15:0] tile_cnt;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state: row buffer indexed by column, queue of tiles not yet handed off.
  logic [9:0] row_buf [32];
  tile_t      mq[$];
  int         m_col;
  int         m_cnt;

  // Per-cycle observations and expectations filled in by tick.
  logic        obs_valid, obs_ready, obs_first, obs_last;
  logic [59:0] obs_tile;
  logic        exp_valid, exp_ready, ho;
  tile_t       exp_t;

  wc_tile_feeder u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .D        (D),
    .d_first  (d_first),
    .d_last   (d_last),
    .tile_cnt (tile_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [59:0] mk_tile(input int base);
    logic [59:0] r;
    for (int k = 0; k < 6; k++) r[10*k +: 10] = 10'(base + k);
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_col = 0;
    m_cnt = 0;
  endtask

  task automatic model_accept(input logic [9:0] sd);
    tile_t t;
    row_buf[m_col] = sd;
    if (m_col >= 5 && ((m_col - 5) % 2) == 0) begin
      for (int k = 0; k < 6; k++) t.d[10*k +: 10] = row_buf[m_col - 5 + k];
      t.first = (m_col == 5);
      t.last  = (m_col == 31);
      mq.push_back(t);
    end
    m_col = (m_col + 1) % 32;
  endtask

  // Drive one cycle at the falling edge, record DUT outputs, advance the model.
  task automatic tick(input logic sv, input logic [9:0] sd, input logic dr);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    d_ready = dr;
    #1;
    exp_valid = (mq.size() != 0);
    exp_ready = !(exp_valid && !dr);
    obs_valid = d_valid;
    obs_ready = s_ready;
    obs_tile  = D;
    obs_first = d_first;
    obs_last  = d_last;
    ho = exp_valid && dr;
    if (ho) begin
      exp_t = mq.pop_front();
      m_cnt++;
    end
    if (sv && exp_ready) model_accept(sd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    d_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic settle();
    @(negedge clk);
    s_valid = 1'b0;
    d_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_run += 6;
    if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
    if (D !== 60'd0) begin n_fail++; $display("FAIL reset_D got %h want 0", D); end
    if (d_first !== 1'b0) begin n_fail++; $display("FAIL reset_d_first got %b want 0", d_first); end
    if (d_last !== 1'b0) begin n_fail++; $display("FAIL reset_d_last got %b want 0", d_last); end
    if (tile_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_tile_cnt got %0d want 0", tile_cnt); end
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_row();
    int k = 0;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      tick(i < 32, 10'(i + 1), 1'b1);
      n_run++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL row_hs cyc %0d got v%b r%b want v%b r%b", i, obs_valid, obs_ready,
                 exp_valid, exp_ready);
      end
      if (ho) begin
        k++;
        n_run++;
        if ({obs_tile, obs_first, obs_last} !== {exp_t.d, exp_t.first, exp_t.last}) begin
          n_fail++;
          $display("FAIL row_tile %0d got %h f%b l%b want %h f%b l%b", k, obs_tile, obs_first,
                   obs_last, exp_t.d, exp_t.first, exp_t.last);
        end
        if (k == 1 || k == 2 || k == 14) begin
          n_run++;
          if (obs_tile !== mk_tile(2 * k - 1) || obs_first !== (k == 1) || obs_last !== (k == 14))
          begin
            n_fail++;
            $display("FAIL row_const %0d got %h f%b l%b want %h", k, obs_tile, obs_first, obs_last,
                     mk_tile(2 * k - 1));
          end
        end
      end
    end
    settle();
    n_run++;
    if (tile_cnt !== 16'd14 || k != 14) begin
      n_fail++;
      $display("FAIL row_cnt got %0d (%0d seen) want 14", tile_cnt, k);
    end
  endtask

  task automatic test_backpressure();
    int idx = 1, stall = 0, k = 0;
    bit started = 0, done = 0;
    logic dr;
    do_reset();
    for (int c = 0; c < 200 && !done; c++) begin
      dr = 1'b1;
      if (!started && mq.size() != 0) begin started = 1; stall = 5; end
      if (stall > 0) begin dr = 1'b0; stall--; end
      tick(idx <= 32, 10'(idx), dr);
      if (idx <= 32 && exp_ready) idx++;
      n_run++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL bp_hs cyc %0d got v%b r%b want v%b r%b", c, obs_valid, obs_ready,
                 exp_valid, exp_ready);
      end
      if (!dr) begin
        n_run++;
        if (obs_tile !== mk_tile(1) || obs_ready !== 1'b0 || obs_first !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold cyc %0d got %h r%b f%b want %h r0 f1", c, obs_tile, obs_ready,
                   obs_first, mk_tile(1));
        end
      end
      if (ho) begin
        k++;
        n_run++;
        if (obs_tile !== mk_tile(2 * k - 1) || obs_last !== (k == 14)) begin
          n_fail++;
          $display("FAIL bp_tile %0d got %h l%b want %h", k, obs_tile, obs_last,
                   mk_tile(2 * k - 1));
        end
      end
      if (idx > 32 && mq.size() == 0 && !ho) done = 1;
    end
    settle();
    n_run++;
    if (!done || tile_cnt !== 16'd14 || k != 14) begin
      n_fail++;
      $display("FAIL bp_cnt done %0d got %0d (%0d seen) want 14", done, tile_cnt, k);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    do_reset();
    for (int i = 0; i < 66; i++) begin
      tick(i < 64, 10'(i + 1), 1'b1);
      n_run++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL b2b_hs cyc %0d got v%b r%b want v%b r%b", i, obs_valid, obs_ready,
                 exp_valid, exp_ready);
      end
      if (ho) begin
        k++;
        n_run++;
        if ({obs_tile, obs_first, obs_last} !== {exp_t.d, exp_t.first, exp_t.last} ||
            (obs_tile[9:0] - 10'd1) / 10'd32 != (obs_tile[59:50] - 10'd1) / 10'd32) begin
          n_fail++;
          $display("FAIL b2b_tile %0d got %h f%b l%b want %h f%b l%b", k, obs_tile, obs_first,
                   obs_last, exp_t.d, exp_t.first, exp_t.last);
        end
        if (k == 15) begin
          n_run++;
          if (obs_tile !== mk_tile(33) || obs_first !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_row2_first got %h f%b want %h f1", obs_tile, obs_first,
                     mk_tile(33));
          end
        end
      end
    end
    settle();
    n_run++;
    if (tile_cnt !== 16'd28) begin
      n_fail++;
      $display("FAIL b2b_cnt got %0d want 28", tile_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int k = 0;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 10'(i + 1), 1'b1);
    do_reset();
    for (int i = 0; i < 34; i++) begin
      tick(i < 32, 10'(100 + i), 1'b1);
      n_run++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL mrst_hs cyc %0d got v%b r%b want v%b r%b", i, obs_valid, obs_ready,
                 exp_valid, exp_ready);
      end
      if (ho) begin
        k++;
        n_run++;
        if ({obs_tile, obs_first, obs_last} !== {exp_t.d, exp_t.first, exp_t.last} ||
            (k == 1 && obs_tile !== mk_tile(100))) begin
          n_fail++;
          $display("FAIL mrst_tile %0d got %h f%b l%b want %h f%b l%b", k, obs_tile, obs_first,
                   obs_last, exp_t.d, exp_t.first, exp_t.last);
        end
        for (int j = 0; j < 6; j++) begin
          if (obs_tile[10*j +: 10] < 10'd100) begin
            n_fail++;
            $display("FAIL mrst_stale tile %0d lane %0d got %0d want >=100", k, j,
                     obs_tile[10*j +: 10]);
          end
        end
      end
    end
    settle();
    n_run++;
    if (tile_cnt !== 16'd14) begin n_fail++; $display("FAIL mrst_cnt got %0d want 14", tile_cnt); end
  endtask

  task automatic test_extremes();
    logic [9:0]  ext [6];
    logic [59:0] want;
    int k = 0;
    ext = '{10'h200, 10'h1FF, 10'h3FF, 10'h000, 10'h001, 10'h2AA};
    for (int j = 0; j < 6; j++) want[10*j +: 10] = ext[j];
    do_reset();
    for (int i = 0; i < 34; i++) begin
      tick(i < 32, (i < 6) ? ext[i] : 10'($urandom), 1'b1);
      if (ho) begin
        k++;
        n_run++;
        if ({obs_tile, obs_first, obs_last} !== {exp_t.d, exp_t.first, exp_t.last} ||
            (k == 1 && obs_tile !== want)) begin
          n_fail++;
          $display("FAIL ext_tile %0d got %h f%b l%b want %h f%b l%b", k, obs_tile, obs_first,
                   obs_last, exp_t.d, exp_t.first, exp_t.last);
        end
      end
    end
    settle();
  endtask

  task automatic test_random();
    int k = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 4) != 0 && i < 580, 10'($urandom), ($urandom % 3) != 0 || i >= 580);
      n_run++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_hs cyc %0d got v%b r%b want v%b r%b", i, obs_valid, obs_ready,
                 exp_valid, exp_ready);
      end
      if (ho) begin
        k++;
        n_run++;
        if ({obs_tile, obs_first, obs_last} !== {exp_t.d, exp_t.first, exp_t.last}) begin
          n_fail++;
          $display("FAIL rand_tile %0d got %h f%b l%b want %h f%b l%b", k, obs_tile, obs_first,
                   obs_last, exp_t.d, exp_t.first, exp_t.last);
        end
      end
    end
    settle();
    n_run++;
    if (tile_cnt !== 16'(m_cnt)) begin
      n_fail++;
      $display("FAIL rand_cnt got %0d want %0d", tile_cnt, m_cnt);
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    d_ready = 1'b0;
    model_reset();
    test_reset();
    test_row();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_extremes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
